// File: rtl/cd_llc_responder.sv
// cd_llc_responder
//
// Purpose:
//   LLC-slice endpoint on the far side of the global crossbar. Request flits
//   from one crossbar LLC output port are queued in a small FIFO, executed one
//   at a time against a local bank of 32-bit words, and answered with a reply
//   flit plus a one-hot destination mask selecting the requesting core.
//
// Build option:
//   CD_LLC_WRITE_ACK_EN  defined   -> every write returns an ack flit (rdata = 0).
//                        undefined -> writes are posted; only reads reply.
//
// Parameters:
//   DATA_W      flit width (only 64 is supported)
//   ADDR_W      bank index width, 1..8 (bank holds 2^ADDR_W words)
//   FIFO_DEPTH  request FIFO entries, power of 2, at least 2
//
// Ports:
//   clk       clock
//   reset     synchronous active-high reset
//   req_si    request flit valid
//   req_ri    request ready (FIFO not full)
//   req_di    request flit {wr, src[2:0], tag[3:0], addr[7:0], ignored[15:0], wdata[31:0]}
//   rep_so    reply flit valid
//   rep_ro    reply accepted (only looked at while a reply is pending)
//   rep_do    reply flit {wr, src, tag, addr, 16'h0, rdata}
//   rep_dst   one-hot destination core, zero when no reply is pending
//   fifo_cnt  request FIFO occupancy

module cd_llc_responder #(
   parameter int DATA_W     = 64,
   parameter int ADDR_W     = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req_si,
   output logic                          req_ri,
   input  logic [DATA_W-1:0]             req_di,
   output logic                          rep_so,
   input  logic                          rep_ro,
   output logic [DATA_W-1:0]             rep_do,
   output logic [7:0]                    rep_dst,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = 48;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_REPLY
   } state_t;

   state_t               state;

   logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic                 push;
   logic                 pop;
   logic [ENTRY_W-1:0]   push_entry;

   logic                 cur_wr;
   logic [2:0]           cur_src;
   logic [3:0]           cur_tag;
   logic [7:0]           cur_addr;
   logic [31:0]          cur_wdata;

   logic [31:0]          bank [2**ADDR_W];
   logic [ADDR_W-1:0]    bank_idx;

   logic                 unused_req_bits;

   // Flit bits [47:32] carry nothing for this slice, so only the header and
   // write data are kept in the FIFO.
   assign push_entry      = {req_di[63:48], req_di[31:0]};
   assign unused_req_bits = ^req_di[47:32];

   // Ready depends only on the registered count, so a full FIFO refuses a
   // push even when the FSM pops in the same cycle.
   assign req_ri   = (fifo_cnt != CNT_W'(FIFO_DEPTH));
   assign push     = req_si && req_ri;
   assign pop      = (state == ST_IDLE) && (fifo_cnt != '0);
   assign bank_idx = cur_addr[ADDR_W-1:0];

   // Request FIFO bookkeeping: pointers wrap naturally because the depth is a
   // power of two, and a simultaneous push/pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // FIFO storage carries no reset; entries are only read after being written.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= push_entry;
      end
   end

   // Bank write port. Contents survive reset so data written before a reset
   // can still be read back afterwards.
   always_ff @(posedge clk) begin
      if (state == ST_ACCESS && cur_wr) begin
         bank[bank_idx] <= cur_wdata;
      end
   end

   // Request sequencer: IDLE pops the FIFO head, ACCESS performs the bank
   // operation and builds the reply, REPLY holds the flit until the crossbar
   // takes it. Reply outputs are registered and cleared whenever no reply is
   // pending so rep_dst reads zero with rep_so low.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         rep_so    <= 1'b0;
         rep_do    <= '0;
         rep_dst   <= '0;
         cur_wr    <= 1'b0;
         cur_src   <= '0;
         cur_tag   <= '0;
         cur_addr  <= '0;
         cur_wdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  {cur_wr, cur_src, cur_tag, cur_addr, cur_wdata} <= fifo_mem[rd_ptr];
                  state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (cur_wr) begin
`ifdef CD_LLC_WRITE_ACK_EN
                  rep_so  <= 1'b1;
                  rep_do  <= {cur_wr, cur_src, cur_tag, cur_addr, 16'h0000, 32'h0000_0000};
                  rep_dst <= 8'b1 << cur_src;
                  state   <= ST_REPLY;
`else
                  state   <= ST_IDLE;
`endif
               end else begin
                  rep_so  <= 1'b1;
                  rep_do  <= {cur_wr, cur_src, cur_tag, cur_addr, 16'h0000, bank[bank_idx]};
                  rep_dst <= 8'b1 << cur_src;
                  state   <= ST_REPLY;
               end
            end
            ST_REPLY: begin
               if (rep_ro) begin
                  rep_so  <= 1'b0;
                  rep_do  <= '0;
                  rep_dst <= '0;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cd_llc_responder.sv
// tb_cd_llc_responder
//
// Purpose:
//   Directed bench for cd_llc_responder. Accepted requests are turned into
//   expected reply flits by a small bank model and queued; every reply the
//   crossbar side takes is popped and compared in order.
//
// Build option:
//   CD_LLC_WRITE_ACK_EN  when defined, write acks are expected as well.

module tb_cd_llc_responder;

   logic        clk;
   logic        reset;
   logic        req_si;
   logic        req_ri;
   logic [63:0] req_di;
   logic        rep_so;
   logic        rep_ro;
   logic [63:0] rep_do;
   logic [7:0]  rep_dst;
   logic [2:0]  fifo_cnt;

   int          checks;
   int          failures;
   int          accepted;
   int          max_cnt;
   logic [63:0] sb [$];
   logic [31:0] model_mem [64];
   logic [63:0] last_rep;
   logic [7:0]  last_dst;
   logic [63:0] hold_do;
   logic [7:0]  hold_dst;
   logic [7:0]  hi_mask;
   int          acc_before;
   int          next_rd;
   logic        acc_now;
   logic        ro_rand;

   cd_llc_responder #(
      .DATA_W     (64),
      .ADDR_W     (6),
      .FIFO_DEPTH (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req_si   (req_si),
      .req_ri   (req_ri),
      .req_di   (req_di),
      .rep_so   (rep_so),
      .rep_ro   (rep_ro),
      .rep_do   (rep_do),
      .rep_dst  (rep_dst),
      .fifo_cnt (fifo_cnt)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something upstream of the cycle budgets goes wrong.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [63:0] mkReq(input logic wr, input logic [2:0] src,
                                          input logic [3:0] tag, input logic [7:0] addr,
                                          input logic [31:0] wdata);
      return {wr, src, tag, addr, 16'h5A5A, wdata};
   endfunction

   // One comparison: counts it and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Bank model: writes update it at acceptance; in-order execution means a
   // read sees the same value the DUT will see.
   task automatic predict(input logic [63:0] di);
      logic [5:0] idx;
      idx = di[53:48];
      if (di[63]) begin
         model_mem[idx] = di[31:0];
`ifdef CD_LLC_WRITE_ACK_EN
         sb.push_back({di[63:48], 16'h0000, 32'h0000_0000});
`endif
      end else begin
         sb.push_back({di[63:48], 16'h0000, model_mem[idx]});
      end
   endtask

   // Drive one cycle of inputs at the falling edge, account for whatever the
   // next rising edge will transfer, then advance to the next falling edge.
   task automatic applyStimulus(input logic si, input logic [63:0] di, input logic ro);
      logic [63:0] exp;
      req_si = si;
      req_di = di;
      rep_ro = ro;
      if (rep_so === 1'b0) begin
         checkOutput("idle_dst", 64'(rep_dst), 64'd0);
      end
      if (si && req_ri === 1'b1) begin
         accepted++;
         predict(di);
      end
      if (rep_so === 1'b1 && ro) begin
         last_rep = rep_do;
         last_dst = rep_dst;
         if (sb.size() == 0) begin
            checkOutput("reply_expected", 64'(sb.size()), 64'd1);
         end else begin
            exp = sb.pop_front();
            checkOutput("reply_flit", rep_do, exp);
            checkOutput("reply_dst", 64'(rep_dst), 64'(8'b1 << exp[62:60]));
         end
      end
      if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
      @(negedge clk);
   endtask

   // Present one request until it is taken, bounded.
   task automatic sendReq(input logic [63:0] req, input logic ro);
      logic done;
      done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         done = (req_ri === 1'b1);
         applyStimulus(1'b1, req, ro);
      end
      checkOutput("send_accepted", 64'(done), 64'd1);
   endtask

   // Let every expected reply come back, bounded, then settle the FSM.
   task automatic drain(input int budget);
      for (int c = 0; c < budget && sb.size() != 0; c++) begin
         applyStimulus(1'b0, '0, 1'b1);
      end
      checkOutput("drain_empty", 64'(sb.size()), 64'd0);
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, '0, 1'b1);
   endtask

   // Stall the reply side until a reply is pending, bounded.
   task automatic waitReply(input int budget);
      for (int c = 0; c < budget && rep_so !== 1'b1; c++) begin
         applyStimulus(1'b0, '0, 1'b0);
      end
      checkOutput("wait_reply", 64'(rep_so), 64'd1);
   endtask

   // Directed sequence.
   initial begin
      checks   = 0;
      failures = 0;
      accepted = 0;
      max_cnt  = 0;
      last_rep = '0;
      last_dst = '0;
      reset    = 1'b1;
      req_si   = 1'b0;
      req_di   = '0;
      rep_ro   = 1'b0;

      repeat (3) @(negedge clk);
      reset = 1'b0;
      $display("[TB] reset state");
      checkOutput("rst_rep_so", 64'(rep_so), 64'd0);
      checkOutput("rst_rep_do", rep_do, 64'd0);
      checkOutput("rst_rep_dst", 64'(rep_dst), 64'd0);
      checkOutput("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
      checkOutput("rst_req_ri", 64'(req_ri), 64'd1);

      $display("[TB] preload addresses 0..19");
      for (int i = 0; i < 20; i++) begin
         sendReq(mkReq(1'b1, 3'(i), 4'(i), 8'(i), 32'hC0DE_0000 | 32'(i)), 1'b1);
      end
      drain(200);

      $display("[TB] write then read");
      sendReq(mkReq(1'b1, 3'd2, 4'd5, 8'h03, 32'hDEAD_BEEF), 1'b1);
      sendReq(mkReq(1'b0, 3'd6, 4'd9, 8'h03, 32'h0), 1'b1);
      drain(50);
      checkOutput("wr_rd_data", 64'(last_rep[31:0]), 64'h0000_0000_DEAD_BEEF);
      checkOutput("wr_rd_dst", 64'(last_dst), 64'h40);
      checkOutput("wr_rd_tag", 64'(last_rep[59:56]), 64'd9);

      $display("[TB] latency");
      applyStimulus(1'b1, mkReq(1'b0, 3'd3, 4'hA, 8'h07, 32'h0), 1'b1);
      hi_mask = '0;
      for (int k = 1; k <= 6; k++) begin
         hi_mask[k] = rep_so;
         applyStimulus(1'b0, '0, 1'b1);
      end
      checkOutput("latency_mask", 64'(hi_mask), 64'h08);
      drain(20);

      $display("[TB] fifo full");
      acc_before = accepted;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, mkReq(1'b0, 3'(i), 4'(i), 8'(10 + i), 32'h0), 1'b0);
      end
      checkOutput("full_req_ri", 64'(req_ri), 64'd0);
      checkOutput("full_fifo_cnt", 64'(fifo_cnt), 64'd4);
      checkOutput("full_accepted", 64'(accepted - acc_before), 64'd5);
      checkOutput("full_rep_so", 64'(rep_so), 64'd1);
      drain(100);
      checkOutput("full_recover_ri", 64'(req_ri), 64'd1);
      checkOutput("full_recover_cnt", 64'(fifo_cnt), 64'd0);

      $display("[TB] backpressure");
      sendReq(mkReq(1'b0, 3'd7, 4'hC, 8'h05, 32'h0), 1'b0);
      waitReply(10);
      hold_do  = rep_do;
      hold_dst = rep_dst;
      for (int k = 0; k < 7; k++) begin
         applyStimulus(1'b0, '0, 1'b0);
         checkOutput("bp_so", 64'(rep_so), 64'd1);
         checkOutput("bp_do", rep_do, hold_do);
         checkOutput("bp_dst", 64'(rep_dst), 64'(hold_dst));
      end
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput("bp_done", 64'(rep_so), 64'd0);
      drain(20);

      $display("[TB] wrap-around stream");
      max_cnt = 0;
      next_rd = 0;
      for (int c = 0; c < 3000 && next_rd < 20; c++) begin
         ro_rand = ($urandom_range(0, 2) == 0);
         acc_now = (req_ri === 1'b1);
         applyStimulus(1'b1, mkReq(1'b0, 3'(next_rd), 4'(next_rd), 8'(next_rd), 32'h0), ro_rand);
         if (acc_now) next_rd++;
      end
      checkOutput("wrap_all_sent", 64'(next_rd), 64'd20);
      drain(400);
      checkOutput("wrap_cnt_bound", 64'(max_cnt <= 4), 64'd1);

      $display("[TB] reset during reply");
      sendReq(mkReq(1'b0, 3'd1, 4'd1, 8'h03, 32'h0), 1'b0);
      sendReq(mkReq(1'b0, 3'd4, 4'd2, 8'h05, 32'h0), 1'b0);
      waitReply(10);
      sendReq(mkReq(1'b0, 3'd0, 4'd3, 8'h08, 32'h0), 1'b0);
      checkOutput("rst_mid_pre_so", 64'(rep_so), 64'd1);
      reset = 1'b1;
      applyStimulus(1'b0, '0, 1'b0);
      reset = 1'b0;
      sb.delete();
      checkOutput("rst_mid_so", 64'(rep_so), 64'd0);
      checkOutput("rst_mid_cnt", 64'(fifo_cnt), 64'd0);
      checkOutput("rst_mid_ri", 64'(req_ri), 64'd1);
      checkOutput("rst_mid_dst", 64'(rep_dst), 64'd0);
      sendReq(mkReq(1'b0, 3'd5, 4'd3, 8'h03, 32'h0), 1'b1);
      drain(20);
      checkOutput("rst_retain_data", 64'(last_rep[31:0]), 64'h0000_0000_DEAD_BEEF);
      checkOutput("rst_retain_dst", 64'(last_dst), 64'h20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cd_llc_responder.md
# cd_llc_responder

LLC-slice endpoint on the far side of the global crossbar. Accepts request flits from one crossbar LLC output port, performs the read or write on a local word-array bank, and returns a reply flit to the crossbar's reply input for that slice, together with a one-hot destination mask selecting the requesting core. Four instances (LLC0..LLC3) terminate the crossbar's request path and source its reply path.

## Interface
- DATA_W, 64, flit width; only 64 is supported.
- ADDR_W, 6, bank index width; must be 1..8; bank holds 2^ADDR_W 32-bit words.
- FIFO_DEPTH, 4, request FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_si  in  1  request flit valid (from crossbar llc_so[k]).
- req_ri  out  1  request ready (to crossbar llc_ro[k]).
- req_di  in  DATA_W  request flit.
- rep_so  out  1  reply flit valid (to crossbar llc_si_r[k]).
- rep_ro  in  1  reply accepted (from crossbar llc_ri_r[k]).
- rep_do  out  DATA_W  reply flit.
- rep_dst  out  8  one-hot destination core (to crossbar dst_r[k]).
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  request FIFO occupancy.

## Operation
- Request flit fields:
  - [63] wr: 1 = write, 0 = read.
  - [62:60] src: requesting core, 0..7.
  - [59:56] tag.
  - [55:48] addr; only the low ADDR_W bits are used.
  - [47:32] ignored.
  - [31:0] wdata.
- Reply flit fields:
  - [63] wr echoed; [62:60] src; [59:56] tag; [55:48] addr echoed in full.
  - [47:32] zero.
  - [31:0] rdata for a read; zero for a write ack.
- rep_dst = 8'b1 << src of the current reply; it is 0 whenever rep_so = 0.
- Request FIFO:
  - Push when req_si & req_ri.
  - req_ri = (fifo_cnt != FIFO_DEPTH).
  - When full, a push is refused even if a pop happens in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the current-request register and go to ACCESS; otherwise stay.
  - ACCESS: for a write, mem[addr] <= wdata; for a read, rdata <= mem[addr]. Then go to REPLY, except a write when CD_LLC_WRITE_ACK_EN is undefined, which goes to IDLE.
  - REPLY: rep_so = 1, and rep_do/rep_dst are held stable. When rep_ro = 1, the transfer completes and the FSM goes to IDLE.
- rep_ro is ignored outside REPLY.
- Requests complete strictly in FIFO order. A read observes every write popped before it.
- Bank contents are not reset; reading an address that was never written returns an undefined value.

## Timing
- Reset values: rep_so = 0, rep_do = 0, rep_dst = 0, fifo_cnt = 0, req_ri = 1 (combinational from count), FSM = IDLE.
- Reset mid-operation: the FIFO empties, any in-flight reply is dropped, and rep_so = 0 in the cycle after reset is sampled. Bank contents are retained.
- Latency: request accepted at edge T, popped at T+1 (IDLE), bank access at T+2, rep_so high from T+3.
- Minimum spacing between replies is 3 cycles (IDLE -> ACCESS -> REPLY with rep_ro = 1).
- A posted write (macro undefined) occupies the FSM for 2 cycles.
- A push and a pop in the same cycle leave fifo_cnt unchanged.
- Backpressure: rep_so stays high and rep_do is stable across any number of cycles with rep_ro = 0. The FIFO keeps accepting requests until it is full.

## Configuration
- CD_LLC_WRITE_ACK_EN defined: every write produces a reply flit (wr = 1, rdata = 0) routed to src.
- CD_LLC_WRITE_ACK_EN undefined: writes are posted and produce no reply; only reads produce reply flits.

## Test plan
- Write then read: write src = 2, tag = 5, addr = 0x03, wdata = 0xDEADBEEF; then read addr = 0x03 from src = 6.
  - Read reply [31:0] = 0xDEADBEEF, rep_dst = 8'h40, tag echoed.
  - With the macro defined, the write ack first, with rep_dst = 8'h04.
- Latency: single read accepted at cycle 10 with rep_ro tied to 1 -> rep_so high only in cycle 13.
- FIFO full: hold rep_ro = 0 and drive 6 back-to-back reads.
  - After 4 pops into the FIFO plus the 1 in the FSM, req_ri = 0 with fifo_cnt = 4.
  - Release rep_ro: all 5 accepted requests reply in order, req_ri recovers, and no request is duplicated or lost.
- Backpressure: in REPLY, hold rep_ro = 0 for 7 cycles -> rep_so, rep_do and rep_dst stay constant; the reply completes on the first rep_ro = 1 cycle.
- Wrap-around: stream 20 reads at addresses 0..19 with random rep_ro stalls -> replies return in order, addresses match, and fifo_cnt never exceeds 4.
- Reset in REPLY: assert reset for 1 cycle while rep_so = 1.
  - Next cycle: rep_so = 0, fifo_cnt = 0, req_ri = 1.
  - A subsequent read of an address written before the reset returns the stored value.
